// File: rtl/mpeg_mv_pkg.sv
// Shared definitions for the MPEG motion-vector encoder and decoder:
// FSM states, code ranges and Table B.10 VLC field sizes.
package mpeg_mv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIFF = 2'd1,
    ST_CODE = 2'd2,
    ST_HOLD = 2'd3
  } mv_state_e;

  localparam int MV_CODE_MAX    = 16;
  localparam int R_SIZE_MAX     = 8;
  localparam int MV_CODE_W      = 6;
  localparam int MV_MAG_W       = 5;
  localparam int RESID_W        = 8;
  // Longest Table B.10 entry is 10 prefix bits plus the sign bit.
  localparam int VLC_CODE_W     = 11;
  localparam int VLC_CODE_LEN_W = 4;
  localparam int VLC_W          = 20;
  localparam int VLC_LEN_W      = 5;

endpackage

// File: rtl/motion_code_vlc.sv
// Table B.10 lookup: motion_code magnitude and sign to right-aligned code
// bits and their length. Magnitude 0 is the single bit "1" with no sign.
module motion_code_vlc
  import mpeg_mv_pkg::*;
(
  input  logic [MV_MAG_W-1:0]       mag_i,
  input  logic                      neg_i,
  output logic [VLC_CODE_W-1:0]     bits_o,
  output logic [VLC_CODE_LEN_W-1:0] len_o
);

  logic [VLC_CODE_W-2:0]     body;
  logic [VLC_CODE_LEN_W-1:0] body_len;

  // NOTE: every output of a combinational block gets a default before the
  // case, otherwise uncovered paths infer latches.
  always_comb begin
    body     = '0;
    body_len = '0;
    case (mag_i)
      5'd1:  begin body = 10'd1;  body_len = 4'd2;  end
      5'd2:  begin body = 10'd1;  body_len = 4'd3;  end
      5'd3:  begin body = 10'd1;  body_len = 4'd4;  end
      5'd4:  begin body = 10'd3;  body_len = 4'd6;  end
      5'd5:  begin body = 10'd5;  body_len = 4'd7;  end
      5'd6:  begin body = 10'd4;  body_len = 4'd7;  end
      5'd7:  begin body = 10'd3;  body_len = 4'd7;  end
      5'd8:  begin body = 10'd11; body_len = 4'd9;  end
      5'd9:  begin body = 10'd10; body_len = 4'd9;  end
      5'd10: begin body = 10'd9;  body_len = 4'd9;  end
      5'd11: begin body = 10'd17; body_len = 4'd10; end
      5'd12: begin body = 10'd16; body_len = 4'd10; end
      5'd13: begin body = 10'd15; body_len = 4'd10; end
      5'd14: begin body = 10'd14; body_len = 4'd10; end
      5'd15: begin body = 10'd13; body_len = 4'd10; end
      5'd16: begin body = 10'd12; body_len = 4'd10; end
      default: ;
    endcase

    if (mag_i == '0) begin
      bits_o = VLC_CODE_W'(1);
      len_o  = VLC_CODE_LEN_W'(1);
    end else if (body_len == '0) begin
      bits_o = '0;
      len_o  = '0;
    end else begin
      bits_o = {body, neg_i};
      len_o  = body_len + VLC_CODE_LEN_W'(1);
    end
  end

endmodule

// File: rtl/encode_motion_vector.sv
// Motion-vector component encoder: differences against the running PMV,
// wraps into the f_code range, splits into motion_code/residual and emits VLC.
module encode_motion_vector
  import mpeg_mv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 slice_start,
  input  logic [W-1:0]         in_vector,
  input  logic [3:0]           r_size,
  input  logic                 full_pel_vector,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [MV_CODE_W-1:0] motion_code,
  output logic [RESID_W-1:0]   motion_residual,
  output logic [VLC_W-1:0]     vlc_bits,
  output logic [VLC_LEN_W-1:0] vlc_len,
  output logic [W-1:0]         out_pred,
  output logic                 err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  mv_state_e           state_q, state_d;
  logic signed [W-1:0] vec_q, vec_d, pmv_q, pmv_d;
  logic [3:0]          rsz_q, rsz_d;
  logic                fp_q, fp_d;
  logic signed [W:0]   d_q, d_d;

  logic [MV_CODE_W-1:0] code_q, code_d;
  logic [RESID_W-1:0]   res_q, res_d;
  logic [VLC_W-1:0]     vlc_q, vlc_d;
  logic [VLC_LEN_W-1:0] len_q, len_d;
  logic [W-1:0]         pred_q, pred_d;
  logic                 err_q, err_d;

  function automatic logic signed [W+1:0] sext2(input logic signed [W-1:0] x_i);
    return {{2{x_i[W-1]}}, x_i};
  endfunction

  // Fold a value into [-span, span-1] with a single +/- 2*span step.
  function automatic logic signed [W+1:0] wrap_range(input logic signed [W+1:0] x_i,
                                                     input logic signed [W+1:0] span_i);
    if (x_i < -span_i) return x_i + (span_i <<< 1);
    if (x_i >= span_i) return x_i - (span_i <<< 1);
    return x_i;
  endfunction

  logic signed [W+1:0] span, v_ext, p_ext, diff_raw, sum_raw;

  assign span     = $signed((W+2)'(MV_CODE_MAX) << rsz_q);
  assign v_ext    = fp_q ? sext2(vec_q >>> 1) : sext2(vec_q);
  assign p_ext    = fp_q ? sext2(pmv_q >>> 1) : sext2(pmv_q);
  assign diff_raw = v_ext - p_ext;
  assign sum_raw  = p_ext + $signed({d_q[W], d_q});

  logic                      d_neg, d_zero, emit_res, rsz_err;
  logic [W:0]                abs_d, a_m1;
  logic [MV_MAG_W-1:0]       code_mag, vlc_mag;
  logic [RESID_W-1:0]        resid;
  logic [VLC_CODE_W-1:0]     code_bits;
  logic [VLC_CODE_LEN_W-1:0] code_len;
  logic [W-1:0]              pmv_wrap, pmv_next;

  assign d_neg    = d_q[W];
  assign d_zero   = (d_q == '0);
  assign abs_d    = d_neg ? -d_q : d_q;
  assign a_m1     = abs_d - (W+1)'(1);
  assign code_mag = MV_MAG_W'(a_m1 >> rsz_q) + MV_MAG_W'(1);
  assign resid    = RESID_W'(a_m1 & (((W+1)'(1) << rsz_q) - (W+1)'(1)));
  assign vlc_mag  = d_zero ? '0 : code_mag;
  assign emit_res = !d_zero && (rsz_q != '0);
  assign rsz_err  = rsz_q > 4'(R_SIZE_MAX);
  assign pmv_wrap = W'(wrap_range(sum_raw, span));
  assign pmv_next = fp_q ? (pmv_wrap << 1) : pmv_wrap;

  motion_code_vlc u_vlc (
    .mag_i  (vlc_mag),
    .neg_i  (d_neg),
    .bits_o (code_bits),
    .len_o  (code_len)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    rsz_d   = rsz_q;
    fp_d    = fp_q;
    d_d     = d_q;
    pmv_d   = pmv_q;
    code_d  = code_q;
    res_d   = res_q;
    vlc_d   = vlc_q;
    len_d   = len_q;
    pred_d  = pred_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        // A slice clear and a new vector on the same cycle: the vector is
        // coded against the cleared PMV, which DIFF reads next cycle.
        if (slice_start) pmv_d = '0;
        if (in_valid) begin
          vec_d   = in_vector;
          rsz_d   = r_size;
          fp_d    = full_pel_vector;
          state_d = ST_DIFF;
        end
      end
      ST_DIFF: begin
        d_d     = (W+1)'(wrap_range(diff_raw, span));
        state_d = ST_CODE;
      end
      ST_CODE: begin
        state_d = ST_HOLD;
        err_d   = rsz_err;
        code_d  = '0;
        res_d   = '0;
        vlc_d   = '0;
        len_d   = '0;
        pred_d  = pmv_q;
        if (!rsz_err) begin
          code_d = d_zero ? '0 : (d_neg ? MV_CODE_W'(0) - MV_CODE_W'(code_mag)
                                        : MV_CODE_W'(code_mag));
          res_d  = d_zero ? '0 : resid;
          vlc_d  = emit_res ? ((VLC_W'(code_bits) << rsz_q) | VLC_W'(resid))
                            : VLC_W'(code_bits);
          len_d  = VLC_LEN_W'(code_len) + (emit_res ? VLC_LEN_W'(rsz_q) : '0);
          pred_d = pmv_next;
          pmv_d  = $signed(pmv_next);
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      rsz_q   <= '0;
      fp_q    <= 1'b0;
      d_q     <= '0;
      pmv_q   <= '0;
      code_q  <= '0;
      res_q   <= '0;
      vlc_q   <= '0;
      len_q   <= '0;
      pred_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      rsz_q   <= rsz_d;
      fp_q    <= fp_d;
      d_q     <= d_d;
      pmv_q   <= pmv_d;
      code_q  <= code_d;
      res_q   <= res_d;
      vlc_q   <= vlc_d;
      len_q   <= len_d;
      pred_q  <= pred_d;
      err_q   <= err_d;
    end
  end

  assign in_ready        = (state_q == ST_IDLE);
  assign out_valid       = (state_q == ST_HOLD);
  assign motion_code     = code_q;
  assign motion_residual = res_q;
  assign vlc_bits        = vlc_q;
  assign vlc_len         = len_q;
  assign out_pred        = pred_q;
  assign err             = err_q;

endmodule

// File: tb/tb_encode_motion_vector.sv
// Scoreboard bench for encode_motion_vector: directed cases plus randomized
// vectors checked against an arithmetic reference model of the coding rules.
module tb_encode_motion_vector;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          slice_start = 1'b0;
  logic [W-1:0]  in_vector = '0;
  logic [3:0]    r_size = '0;
  logic          full_pel_vector = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    motion_code;
  logic [7:0]    motion_residual;
  logic [19:0]   vlc_bits;
  logic [4:0]    vlc_len;
  logic [W-1:0]  out_pred;
  logic          err;
  logic          out_valid;
  logic          out_ready = 1'b1;

  encode_motion_vector #(.W(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .slice_start     (slice_start),
    .in_vector       (in_vector),
    .r_size          (r_size),
    .full_pel_vector (full_pel_vector),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .motion_code     (motion_code),
    .motion_residual (motion_residual),
    .vlc_bits        (vlc_bits),
    .vlc_len         (vlc_len),
    .out_pred        (out_pred),
    .err             (err),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int res;
    int vlc;
    int len;
    int pred;
    bit err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_pmv  = 0;
  bit   rand_bp = 1'b0;

  // Table B.10 prefixes (sign bit appended separately), indexed by |code|.
  string vlc_tab [0:16] = '{"1", "01", "001", "0001", "000011", "0000101",
                            "0000100", "0000011", "000001011", "000001010",
                            "000001001", "0000010001", "0000010000",
                            "0000001111", "0000001110", "0000001101",
                            "0000001100"};

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int vec, input int r, input bit fp, input int pmv);
    exp_t   e;
    longint f, v, p, d, a, mag, s;
    string  bits;
    e = '{code: 0, res: 0, vlc: 0, len: 0, pred: pmv, err: 1'b0};
    if (r > 8) begin
      e.err = 1'b1;
      return e;
    end
    f = longint'(1) << r;
    v = fp ? longint'(vec >>> 1) : longint'(vec);
    p = fp ? longint'(pmv >>> 1) : longint'(pmv);
    d = v - p;
    if (d < -16 * f) d += 32 * f;
    else if (d >= 16 * f) d -= 32 * f;
    if (d == 0) begin
      bits = "1";
    end else begin
      a      = (d < 0 ? -d : d) - 1;
      mag    = a / f + 1;
      e.res  = int'(a % f);
      e.code = int'(d < 0 ? -mag : mag);
      bits   = $sformatf("%s%0d", vlc_tab[int'(mag)], (d < 0) ? 1 : 0);
      for (int i = r - 1; i >= 0; i--) bits = $sformatf("%s%0d", bits, (e.res >> i) & 1);
    end
    e.len = bits.len();
    for (int i = 0; i < bits.len(); i++) e.vlc = (e.vlc << 1) | ((bits[i] == 8'h31) ? 1 : 0);
    s = p + d;
    if (s < -16 * f) s += 32 * f;
    else if (s >= 16 * f) s -= 32 * f;
    if (fp) s = s * 2;
    e.pred = int'(s);
    return e;
  endfunction

  // Monitor: every presented output is compared against the scoreboard head;
  // the head is retired only on the handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_out_valid", out_valid, 0);
      end else begin
        check("motion_code", $signed(motion_code), sb_q[0].code);
        check("motion_residual", motion_residual, sb_q[0].res);
        check("vlc_bits", vlc_bits, sb_q[0].vlc);
        check("vlc_len", vlc_len, sb_q[0].len);
        check("out_pred", $signed(out_pred), sb_q[0].pred);
        check("err", err, sb_q[0].err);
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic send(input int vec, input int r, input bit fp, input bit ss);
    int   n;
    exp_t e;
    @(negedge clk);
    in_vector       = vec;
    r_size          = 4'(r);
    full_pel_vector = fp;
    slice_start     = ss;
    in_valid        = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_ready", in_ready, 1);
    if (in_ready) begin
      if (ss) m_pmv = 0;
      e = model(vec, r, fp, m_pmv);
      m_pmv = e.pred;
      sb_q.push_back(e);
      @(posedge clk);
    end
    #1;
    in_valid    = 1'b0;
    slice_start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r, prev_max, f, vec, n;
    bit fp, ss;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_motion_code", motion_code, 0);
    check("rst_residual", motion_residual, 0);
    check("rst_vlc_bits", vlc_bits, 0);
    check("rst_vlc_len", vlc_len, 0);
    check("rst_out_pred", out_pred, 0);
    check("rst_err", err, 0);

    // Basic positive, with latency checks: valid rises after accept edge + 2.
    send(3, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("latency_diff", out_valid, 0);
    @(negedge clk);
    check("latency_code", out_valid, 0);
    @(negedge clk);
    check("latency_hold", out_valid, 1);
    drain();

    send(45, 2, 1'b0, 1'b1);
    drain();
    send(15, 0, 1'b0, 1'b1);
    send(-16, 0, 1'b0, 1'b0);
    drain();
    send(10, 1, 1'b0, 1'b1);
    send(3, 1, 1'b0, 1'b0);
    drain();
    send(8, 0, 1'b1, 1'b1);
    send(8, 0, 1'b1, 1'b0);
    drain();

    // Illegal r_size leaves the PMV alone; the following zero-diff proves it.
    send(100, 9, 1'b0, 1'b0);
    send(8, 0, 1'b1, 1'b0);
    drain();

    // Backpressure: outputs held, in_ready low, slice_start ignored.
    out_ready = 1'b0;
    send(5, 0, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("hold_valid_rose", out_valid, 1);
    slice_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    slice_start = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    send(5, 0, 1'b0, 1'b0);
    drain();

    // Standalone slice_start in IDLE clears the PMV.
    @(negedge clk);
    slice_start = 1'b1;
    @(negedge clk);
    slice_start = 1'b0;
    m_pmv = 0;
    send(-7, 1, 1'b0, 1'b0);
    drain();

    // Reset while in DIFF aborts the vector: no output may appear.
    send(20, 1, 1'b0, 1'b0);
    rst = 1'b1;
    void'(sb_q.pop_back());
    m_pmv = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_out_valid", out_valid, 0);
    end
    check("abort_in_ready", in_ready, 1);
    send(-20, 1, 1'b0, 1'b0);
    drain();

    // Randomized vectors with backpressure; the PMV is cleared whenever
    // f shrinks so every difference stays codable.
    rand_bp  = 1'b1;
    prev_max = 0;
    for (int k = 0; k < 300; k++) begin
      r  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      fp = 1'($urandom_range(0, 1));
      ss = ($urandom_range(0, 9) == 0);
      if (r <= 8) begin
        if (r < prev_max) ss = 1'b1;
        prev_max = ss ? r : ((r > prev_max) ? r : prev_max);
      end else if (ss) begin
        prev_max = 0;
      end
      f = 1 << ((r > 8) ? 0 : r);
      case ($urandom_range(0, 7))
        0:       vec = -16 * f;
        1:       vec = 16 * f - 1;
        default: vec = int'($urandom_range(0, 32 * f - 1)) - 16 * f;
      endcase
      send(vec, r, fp, ss);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encode_motion_vector.md
# encode_motion_vector

Encodes one motion-vector component for the MPEG bitstream writer. It is the inverse of `decode_motion_vector`. Each accepted vector is differenced against the running prediction (PMV) and wrapped into the legal f_code range. The block then splits the difference into a signed motion_code and a motion_residual, and emits the concatenated VLC + residual bits. It updates its PMV so that a decoder fed the same bits reconstructs the identical vector.

## Interface
Parameters:
- `W`, default 32: vector and prediction width, two's complement.

Ports (name, direction, width, meaning):
- `clk`, in, 1: the block's single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `slice_start`, in, 1: synchronous clear of the PMV to 0. Honoured only in IDLE.
- `in_vector`, in, W: target vector, in half-pel units.
- `r_size`, in, 4: f_code−1. Legal values are 0..8.
- `full_pel_vector`, in, 1: full-pel coding for this vector.
- `in_valid`, in, 1: input valid.
- `in_ready`, out, 1: input accepted when `in_valid` and `in_ready` are both high.
- `motion_code`, out, 6: signed, −16..16.
- `motion_residual`, out, 8: unsigned residual, 0..f−1.
- `vlc_bits`, out, 20: Table B.10 code followed by the residual, right-aligned.
- `vlc_len`, out, 5: number of valid bits in `vlc_bits`, 1..19.
- `out_pred`, out, W: new PMV, which equals the decoder's `out_pred`.
- `err`, out, 1: `r_size` > 8 on this vector.
- `out_valid`, in/out: out, 1: output valid.
- `out_ready`, in, 1: output consumed when `out_valid` and `out_ready` are both high.

## Operation
- f = 1<<r_size. Legal range is [−16f, 16f−1].
- Full-pel handling: if `full_pel_vector` is set, v = in_vector>>>1 and p = pmv>>>1. Otherwise v = in_vector and p = pmv.
- Difference: d = v − p, computed at W+1 bits.
  - If d < −16f, d += 32f.
  - If d ≥ 16f, d −= 32f.
- Coding when d = 0: motion_code = 0, residual = 0, no residual bits are emitted.
- Coding when d ≠ 0:
  - a = |d| − 1.
  - Code magnitude = (a>>r_size) + 1, with the sign of d.
  - residual = a & (f−1).
  - Residual bits (r_size of them) are appended only when r_size > 0 and code ≠ 0.
- VLC: sign bit s is 1 for a negative code. Table B.10 gives, for example:
  - 0 → "1"
  - ±1 → "01s"
  - ±3 → "0001s"
  - ±4 → "000011s"
  - ±12 → "0000010000s"
- New PMV: pmv_new = p + d, re-wrapped into the range, then <<1 if full-pel. `out_pred` = pmv_new.
- Error case: if r_size > 8, then err = 1, all code outputs are 0, `vlc_len` = 0, and the PMV is unchanged.

## Timing
- FSM states are IDLE, DIFF, CODE and HOLD.
- `in_ready` = 1 only in IDLE.
- Transitions:
  - IDLE → DIFF on accept. `in_vector`, `r_size` and `full_pel_vector` are registered; the wrapped d is registered at the DIFF edge.
  - DIFF → CODE is unconditional. The code, residual and VLC are registered and the PMV is updated at the CODE edge.
  - CODE → HOLD: `out_valid` = 1.
  - HOLD → IDLE on `out_ready`.
- Latency: accept at edge N gives `out_valid` high after edge N+2. Throughput is one vector per 4 cycles with no stall.
- While `out_valid` is high and `out_ready` is low, all outputs are held stable.
- `slice_start` together with `in_valid` in IDLE: the PMV is cleared first, then the vector is coded against 0.
- `slice_start` in other states is ignored.
- Reset values: state = IDLE, PMV = 0, `in_ready` = 1 after reset deasserts, `out_valid` = 0, and every data output including `err` = 0.
- A reset mid-operation aborts the vector. No output is produced for it.

## Structure
- Package `mpeg_mv_pkg` holds:
  - the FSM state enum;
  - `MV_CODE_MAX` = 16;
  - `R_SIZE_MAX` = 8;
  - the VLC width/length constants.
- Sub-module `motion_code_vlc`: combinational Table B.10 lookup. It takes |code| and the sign and returns code bits and length. The decoder side's VLC parser reuses the same table constants.

## Test plan
- Basic positive: r_size=0, PMV=0, vector 3. Expect code +3, residual 0, `vlc_bits` "00010", len 5, `out_pred` 3.
- Positive with residual field: r_size=2, PMV=0, vector 45. Expect code +12, residual 0, `vlc_bits` "0000010000000", len 13, `out_pred` 45.
- Wrap-around: r_size=0, PMV=15, vector −16. Here d = −31, which wraps to 1. Expect code +1, "010", len 3, `out_pred` −16.
- Negative with residual: r_size=1, PMV=10, vector 3. Here d = −7. Expect code −4, residual 0, "00001110", len 8.
- Full-pel and zero difference:
  - full_pel=1, r_size=0, PMV=0, vector 8: expect code +4, `out_pred` 8.
  - Then vector 8 again: expect code 0, "1", len 1.
- Control behaviour:
  - Hold `out_ready` low for 5 cycles; outputs must stay stable and `in_ready` must stay 0.
  - `slice_start` clears the PMV.
  - r_size=9: expect err=1, `vlc_len` 0, PMV unchanged.
  - Reset asserted in DIFF: expect `out_valid` to never rise.
